reg_cmd_sequencer: RTL and testbench

// Upstream control stage for the 4-bit universal register (hold/invert/clear/load).
// - Accepts register commands over a valid/ready handshake and buffers them in a small FIFO.
// - Replays each command for 1..2^RPTW cycles and drives the register's d/s1/s0 inputs.
// - Keeps a mirror of the register contents so downstream logic and benches have a golden value.
//

---
 rtl/reg_cmd_sequencer_if.sv | 10 +
 rtl/reg_cmd_sequencer.sv | 84 ++++++++
 tb/tb_reg_cmd_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reg_cmd_sequencer_if.sv
// reg_cmd_sequencer_if: valid/ready command channel into the register sequencer
interface reg_cmd_sequencer_if #(parameter int RPTW = 3);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [3:0]      cmd_data;
  logic [RPTW-1:0] cmd_rpt;
  modport master (output cmd_valid, cmd_op, cmd_data, cmd_rpt, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_rpt, output cmd_ready);
endinterface

// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer: queues register commands, replays each rpt+1 times and mirrors the register
module reg_cmd_sequencer #(
  parameter int DEPTH = 2,
  parameter int RPTW  = 3
) (
  input  logic                 i_c,
  input  logic                 i_nrst,
  reg_cmd_sequencer_if.slave   cmd,
  output logic [3:0]           o_d,
  output logic                 o_s1,
  output logic                 o_s0,
  output logic [3:0]           o_q_mir,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {INIT, IDLE, ISSUE} state_t;
  state_t          r_state;
  logic [1:0]      r_op  [DEPTH];
  logic [3:0]      r_dat [DEPTH];
  logic [RPTW-1:0] r_rpt [DEPTH];
  logic [AW:0]     r_wp, r_rp;
  logic [RPTW-1:0] r_cnt;
  logic            w_empty, w_full, w_push, w_pop, w_last;
  logic [1:0]      w_hop;
  logic [3:0]      w_hdat;
  logic [RPTW-1:0] w_hrpt;
  assign w_empty       = r_wp == r_rp;
  assign w_full        = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign cmd.cmd_ready = !w_full && r_state != INIT;
  assign w_push        = cmd.cmd_valid && cmd.cmd_ready;
  assign w_last        = r_state == ISSUE && r_cnt == '0;
  assign w_pop         = !w_empty && (r_state == IDLE || w_last);
  assign w_hop         = r_op[r_rp[AW-1:0]];
  assign w_hdat        = r_dat[r_rp[AW-1:0]];
  assign w_hrpt        = r_rpt[r_rp[AW-1:0]];
  assign o_busy        = r_state != IDLE || !w_empty;
  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_c)
    if (w_push) begin
      r_op[r_wp[AW-1:0]]  <= cmd.cmd_op;
      r_dat[r_wp[AW-1:0]] <= cmd.cmd_data;
      r_rpt[r_wp[AW-1:0]] <= cmd.cmd_rpt;
    end
  // FIFO pointers with wrap bit; reset empties the queue
  always_ff @(posedge i_c or negedge i_nrst)
    if (!i_nrst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  // Sequencer FSM; outputs are loaded for the cycle being entered so a pop issues next cycle
  always_ff @(posedge i_c or negedge i_nrst)
    if (!i_nrst) begin
      r_state      <= INIT;
      {o_s1, o_s0} <= 2'b00;
      o_d          <= '0;
      o_done       <= 1'b0;
      r_cnt        <= '0;
    end else if (r_state == INIT) begin
      {o_s1, o_s0} <= o_s1 ? 2'b00 : 2'b10;
      if (o_s1) r_state <= IDLE;
    end else if (w_pop) begin
      r_state      <= ISSUE;
      {o_s1, o_s0} <= w_hop;
      o_d          <= w_hop == 2'b11 ? w_hdat : 4'h0;
      r_cnt        <= w_hrpt;
      o_done       <= w_hrpt == '0;
    end else if (r_state == ISSUE && !w_last) begin
      r_cnt  <= r_cnt - 1'b1;
      o_done <= r_cnt == RPTW'(1);
    end else begin
      r_state      <= IDLE;
      {o_s1, o_s0} <= 2'b00;
      o_d          <= '0;
      o_done       <= 1'b0;
    end
  // Golden copy of the register, following the select and data actually driven
  always_ff @(posedge i_c or negedge i_nrst)
    if (!i_nrst) o_q_mir <= '0;
    else o_q_mir <= !o_s1 ? (o_s0 ? ~o_q_mir : o_q_mir) : (o_s0 ? o_d : 4'h0);
endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// tb_reg_cmd_sequencer: directed checks of the sequencer plus a register model for random traffic
module tb_reg_cmd_sequencer;
  logic       c = 1'b0;
  logic       nrst;
  logic [3:0] o_d, o_q_mir, q_reg;
  logic       o_s1, o_s0, o_busy, o_done;
  int         n_chk = 0, n_fail = 0, n_ld = 0, w;
  int         waits [4];
  int         log_q [$];
  logic       mon_en = 1'b0, en6 = 1'b0;
  logic [3:0] exp_d [5] = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] exp_q [5] = '{4'hA, 4'h5, 4'hA, 4'h5, 4'hA};
  logic [1:0] exp_s [5] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
  logic       exp_dn [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  reg_cmd_sequencer_if #(.RPTW(3)) bus ();
  reg_cmd_sequencer #(.DEPTH(2), .RPTW(3)) dut (
    .i_c(c), .i_nrst(nrst), .cmd(bus), .o_d(o_d), .o_s1(o_s1), .o_s0(o_s0),
    .o_q_mir(o_q_mir), .o_busy(o_busy), .o_done(o_done));
  always #5 c = ~c;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge c);
    #1;
  endtask
  task automatic push(input logic [1:0] op, input logic [3:0] dat, input logic [2:0] rpt, output int n);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = dat;
    bus.cmd_rpt   = rpt;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(o_busy), 0);
  endtask
  // external universal register driven by the sequencer outputs
  always @(posedge c)
    q_reg <= !o_s1 ? (o_s0 ? ~q_reg : q_reg) : (o_s0 ? o_d : 4'h0);
  always @(negedge c) begin
    if (en6) chk("mirror_vs_reg", 32'(o_q_mir), 32'(q_reg));
    if (mon_en && o_done) log_q.push_back(int'(o_d));
    if (mon_en && {o_s1, o_s0} == 2'b11) n_ld++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    nrst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_data = 4'h0;
    bus.cmd_rpt = 3'd0;
    #3;
    chk("rst_d", 32'(o_d), 0);
    chk("rst_s", 32'({o_s1, o_s0}), 0);
    chk("rst_q", 32'(o_q_mir), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_busy", 32'(o_busy), 1);
    chk("rst_ready", 32'(bus.cmd_ready), 0);
    repeat (2) @(posedge c);
    @(negedge c) nrst = 1'b1;
    tick();
    chk("init_s", 32'({o_s1, o_s0}), 2);
    chk("init_busy", 32'(o_busy), 1);
    chk("init_ready", 32'(bus.cmd_ready), 0);
    tick();
    chk("idle_s", 32'({o_s1, o_s0}), 0);
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_ready", 32'(bus.cmd_ready), 1);
    repeat (3) tick();
    chk("idle_s_later", 32'({o_s1, o_s0}), 0);
    chk("idle_q", 32'(o_q_mir), 0);
    push(2'b11, 4'hA, 3'd0, w);
    chk("ld_wait_s", 32'({o_s1, o_s0}), 0);
    chk("ld_wait_busy", 32'(o_busy), 1);
    tick();
    chk("ld_s", 32'({o_s1, o_s0}), 3);
    chk("ld_d", 32'(o_d), 32'hA);
    chk("ld_done", 32'(o_done), 1);
    tick();
    chk("ld_q", 32'(o_q_mir), 32'hA);
    chk("ld_done_end", 32'(o_done), 0);
    chk("ld_busy_end", 32'(o_busy), 0);
    push(2'b11, 4'h5, 3'd0, w);
    push(2'b01, 4'hF, 3'd2, w);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk($sformatf("b2b_s%0d", i), 32'({o_s1, o_s0}), 32'(exp_s[i]));
      chk($sformatf("b2b_d%0d", i), 32'(o_d), 32'(exp_d[i]));
      chk($sformatf("b2b_q%0d", i), 32'(o_q_mir), 32'(exp_q[i]));
      chk($sformatf("b2b_done%0d", i), 32'(o_done), 32'(exp_dn[i]));
    end
    mon_en = 1'b1;
    push(2'b11, 4'h1, 3'd7, waits[0]);
    push(2'b11, 4'h2, 3'd0, waits[1]);
    push(2'b11, 4'h3, 3'd0, waits[2]);
    chk("full_ready", 32'(bus.cmd_ready), 0);
    push(2'b11, 4'h4, 3'd0, waits[3]);
    for (int i = 0; i < 4; i++) chk($sformatf("full_wait%0d", i), 32'(waits[i]), i == 3 ? 7 : 0);
    wait_idle();
    mon_en = 1'b0;
    chk("full_count", 32'(log_q.size()), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk($sformatf("full_order%0d", i), 32'(log_q[i]), 32'(i + 1));
    chk("full_ld_cycles", 32'(n_ld), 11);
    push(2'b01, 4'h0, 3'd7, w);
    push(2'b11, 4'hF, 3'd0, w);
    tick();
    tick();
    chk("mid_s", 32'({o_s1, o_s0}), 1);
    #2 nrst = 1'b0;
    #1;
    chk("arst_d", 32'(o_d), 0);
    chk("arst_s", 32'({o_s1, o_s0}), 0);
    chk("arst_q", 32'(o_q_mir), 0);
    chk("arst_done", 32'(o_done), 0);
    chk("arst_busy", 32'(o_busy), 1);
    chk("arst_ready", 32'(bus.cmd_ready), 0);
    @(negedge c) nrst = 1'b1;
    tick();
    chk("arst_init_s", 32'({o_s1, o_s0}), 2);
    tick();
    chk("arst_idle_s", 32'({o_s1, o_s0}), 0);
    repeat (3) tick();
    chk("arst_flushed", 32'(o_busy), 0);
    chk("arst_s_hold", 32'({o_s1, o_s0}), 0);
    chk("arst_q_hold", 32'(o_q_mir), 0);
    en6 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      push(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)), w);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    tick();
    en6 = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
